// File: rtl/my_ram_pkg.sv
// Shared types and helpers for the my_ram_bank data-memory block.
package my_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int LAT_MAX = 2;

   function automatic int bytes_of(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/my_ram_bank_if.sv
// Access port of my_ram_bank; errInject/parityErr exist only with MY_RAM_BANK_PARITY_EN.
interface my_ram_bank_if
   import my_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
);
   // WE/RE are accepted on any rising edge where busy is low (no back-pressure otherwise);
   // dataValid is a one-cycle strobe marking the cycle dataOut carries a new read word.
   logic                      WE;
   logic [DATA_WIDTH/8-1:0]   byteEn;
   logic                      RE;
   logic [ADDR_WIDTH-1:0]     address;
   logic [DATA_WIDTH-1:0]     dataIn;
   logic                      clearReq;
   logic [DATA_WIDTH-1:0]     dataOut;
   logic                      dataValid;
   logic                      busy;
   logic                      addrErr;
   state_t                    seq_state;
`ifdef MY_RAM_BANK_PARITY_EN
   logic                      errInject;
   logic                      parityErr;

   modport master (
      output WE, byteEn, RE, address, dataIn, clearReq, errInject,
      input  dataOut, dataValid, busy, addrErr, parityErr, seq_state
   );
   modport slave (
      input  WE, byteEn, RE, address, dataIn, clearReq, errInject,
      output dataOut, dataValid, busy, addrErr, parityErr, seq_state
   );
`else
   modport master (
      output WE, byteEn, RE, address, dataIn, clearReq,
      input  dataOut, dataValid, busy, addrErr, seq_state
   );
   modport slave (
      input  WE, byteEn, RE, address, dataIn, clearReq,
      output dataOut, dataValid, busy, addrErr, seq_state
   );
`endif
endinterface

// File: rtl/my_ram_clear_seq.sv
// Clear sequencer: walks every word once after reset or on request, owning the busy flag.
module my_ram_clear_seq
   import my_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output state_t                state_dbg
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // clear_req is only looked at in READY, so a request mid-sweep never restarts it.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      case (state)
         CLEAR: begin
            clr_we = 1'b1;
            if (cnt == LAST) begin
               state_nxt = READY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + ADDR_WIDTH'(1);
            end
         end
         READY: begin
            if (clear_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign busy      = (state == CLEAR);
   assign clr_addr  = cnt;
   assign state_dbg = state;

endmodule

// File: rtl/my_ram_bank.sv
// Single-port RAM bank with byte enables, 1/2-cycle registered reads and a clear sweep.
// Optional per-byte even parity is enabled with MY_RAM_BANK_PARITY_EN.
module my_ram_bank
   import my_ram_pkg::*;
#(
   parameter int                     ADDR_WIDTH   = 10,
   parameter int                     DATA_WIDTH   = 16,
   parameter int                     DEPTH        = 1 << ADDR_WIDTH,
   parameter int                     READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0]  INIT_VALUE   = '0
) (
   input  logic          clk,
   input  logic          rst,
   my_ram_bank_if.slave  bus
);

   localparam int NB  = bytes_of(DATA_WIDTH);
   localparam int LAT = (READ_LATENCY >= LAT_MAX) ? LAT_MAX : 1;

   logic                  busy;
   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;

   my_ram_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_clear_seq (
      .clk       (clk),
      .rst       (rst),
      .clear_req (bus.clearReq),
      .busy      (busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .state_dbg (bus.seq_state)
   );

   assign bus.busy = busy;

   // A full-depth bank has no out-of-range addresses, so the compare is elided.
   logic in_range;
   generate
      if (DEPTH < (1 << ADDR_WIDTH)) begin : g_partial
         localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH);
         assign in_range = (bus.address < LIMIT);
      end else begin : g_full
         assign in_range = 1'b1;
      end
   endgenerate

   logic wr_ok, rd_ok, acc_err;
   assign wr_ok   = !busy && bus.WE && in_range;
   assign rd_ok   = !busy && bus.RE;
   assign acc_err = !busy && (bus.WE || bus.RE) && !in_range;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_word;

   assign rd_word = in_range ? mem[bus.address] : '0;

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= INIT_VALUE;
      end else if (wr_ok) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.byteEn[b]) mem[bus.address][8*b +: 8] <= bus.dataIn[8*b +: 8];
         end
      end
   end

   // First read stage; the word is sampled before this edge's write lands (read-first).
   logic                  v1, e1;
   logic [DATA_WIDTH-1:0] d1;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         e1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= rd_ok;
         e1 <= acc_err;
         if (rd_ok) d1 <= rd_word;
      end
   end

   generate
      if (LAT == 1) begin : g_lat1
         assign bus.dataOut   = d1;
         assign bus.dataValid = v1;
         assign bus.addrErr   = e1;
      end else begin : g_lat2
         logic                  v2, e2;
         logic [DATA_WIDTH-1:0] d2;
         always_ff @(posedge clk) begin
            if (rst) begin
               v2 <= 1'b0;
               e2 <= 1'b0;
               d2 <= '0;
            end else begin
               v2 <= v1;
               e2 <= e1;
               if (v1) d2 <= d1;
            end
         end
         assign bus.dataOut   = d2;
         assign bus.dataValid = v2;
         assign bus.addrErr   = e2;
      end
   endgenerate

`ifdef MY_RAM_BANK_PARITY_EN
   function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] w);
      logic [NB-1:0] p;
      p = '0;
      for (int b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
      return p;
   endfunction

   logic [NB-1:0] pmem [DEPTH];
   logic [NB-1:0] wr_par;
   logic          rd_perr;
   logic          p1;

   assign wr_par  = byte_par(bus.dataIn) ^ {NB{bus.errInject}};
   assign rd_perr = in_range && (|(byte_par(mem[bus.address]) ^ pmem[bus.address]));

   always_ff @(posedge clk) begin
      if (clr_we) begin
         pmem[clr_addr] <= byte_par(INIT_VALUE);
      end else if (wr_ok) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.byteEn[b]) pmem[bus.address][b] <= wr_par[b];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) p1 <= 1'b0;
      else     p1 <= rd_ok && rd_perr;
   end

   generate
      if (LAT == 1) begin : g_par1
         assign bus.parityErr = p1;
      end else begin : g_par2
         logic p2;
         always_ff @(posedge clk) begin
            if (rst) p2 <= 1'b0;
            else     p2 <= p1;
         end
         assign bus.parityErr = p2;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_my_ram_bank.sv
// Bench for my_ram_bank: a full-depth latency-1 bank and a 1000-word latency-2 bank share stimulus.
module tb_my_ram_bank;
   import my_ram_pkg::*;

   localparam int AW    = 10;
   localparam int DW    = 16;
   localparam int NBY   = DW / 8;
   localparam int DEP_A = 1024;
   localparam int LAT_A = 1;
   localparam int DEP_B = 1000;
   localparam int LAT_B = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic           we = 1'b0, re = 1'b0, clr = 1'b0, inj = 1'b0;
   logic [NBY-1:0] be = '0;
   logic [AW-1:0]  addr = '0;
   logic [DW-1:0]  din = '0;

   my_ram_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
   my_ram_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

   assign bus_a.WE = we;       assign bus_b.WE = we;
   assign bus_a.RE = re;       assign bus_b.RE = re;
   assign bus_a.byteEn = be;   assign bus_b.byteEn = be;
   assign bus_a.address = addr; assign bus_b.address = addr;
   assign bus_a.dataIn = din;  assign bus_b.dataIn = din;
   assign bus_a.clearReq = clr; assign bus_b.clearReq = clr;
`ifdef MY_RAM_BANK_PARITY_EN
   assign bus_a.errInject = inj; assign bus_b.errInject = inj;
`endif

   my_ram_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP_A), .READ_LATENCY(LAT_A))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   my_ram_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP_B), .READ_LATENCY(LAT_B))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      int            due;
      logic          rd;
      logic          err;
      logic [DW-1:0] data;
      logic          perr;
   } exp_t;

   exp_t           exp_q_a[$];
   exp_t           exp_q_b[$];
   logic [DW-1:0]  ref_mem [2][1024];
   logic [NBY-1:0] ref_bad [2][1024];
   int             busy_left [2];
   logic [DW-1:0]  ref_dout [2];
   int             depth [2] = '{DEP_A, DEP_B};
   int             lat   [2] = '{LAT_A, LAT_B};
   int             cyc = 0;
   int             total = 0;
   int             bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic wipe(input int k);
      for (int i = 0; i < 1024; i++) begin
         ref_mem[k][i] = '0;
         ref_bad[k][i] = '0;
      end
   endtask

   // Transaction-level view of one rising edge for bank k.
   task automatic model_edge(input int k);
      exp_t e;
      logic inr;
      if (rst) begin
         busy_left[k] = depth[k];
         ref_dout[k]  = '0;
         if (k == 0) exp_q_a.delete(); else exp_q_b.delete();
         wipe(k);
      end else if (busy_left[k] > 0) begin
         busy_left[k]--;
      end else begin
         inr = (int'(addr) < depth[k]);
         if (re || (we && !inr)) begin
            e.due  = cyc + lat[k] - 1;
            e.rd   = re;
            e.err  = !inr;
            e.data = (re && inr) ? ref_mem[k][addr] : '0;
            e.perr = re && inr && (ref_bad[k][addr] != '0);
            if (k == 0) exp_q_a.push_back(e); else exp_q_b.push_back(e);
         end
         if (we && inr) begin
            for (int b = 0; b < NBY; b++) begin
               if (be[b]) begin
                  ref_mem[k][addr][8*b +: 8] = din[8*b +: 8];
                  ref_bad[k][addr][b]        = inj;
               end
            end
         end
         if (clr) begin
            busy_left[k] = depth[k];
            wipe(k);
         end
      end
   endtask

   task automatic check_out(input int k);
      exp_t  e;
      logic  found = 1'b0;
      logic  ev = 1'b0, ee = 1'b0, ep = 1'b0;
      string nm = (k == 0) ? "a" : "b";
      if (k == 0 && exp_q_a.size() > 0 && exp_q_a[0].due == cyc) begin
         e = exp_q_a.pop_front();
         found = 1'b1;
      end
      if (k == 1 && exp_q_b.size() > 0 && exp_q_b[0].due == cyc) begin
         e = exp_q_b.pop_front();
         found = 1'b1;
      end
      if (found) begin
         ev = e.rd;
         ee = e.err;
         ep = e.perr;
         if (e.rd) ref_dout[k] = e.data;
      end
      check({nm, ".valid"}, (k == 0) ? bus_a.dataValid : bus_b.dataValid, ev);
      check({nm, ".addr_err"}, (k == 0) ? bus_a.addrErr : bus_b.addrErr, ee);
      check({nm, ".data"}, (k == 0) ? bus_a.dataOut : bus_b.dataOut, ref_dout[k]);
      check({nm, ".busy"}, (k == 0) ? bus_a.busy : bus_b.busy, busy_left[k] > 0);
`ifdef MY_RAM_BANK_PARITY_EN
      check({nm, ".parity_err"}, (k == 0) ? bus_a.parityErr : bus_b.parityErr, ep);
`else
      if (ep) check({nm, ".parity_unexpected"}, 32'd1, 32'd0);
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge(0);
      model_edge(1);
      #1;
      check_out(0);
      check_out(1);
   endtask

   task automatic idle();
      we = 1'b0; re = 1'b0; clr = 1'b0; inj = 1'b0; be = '0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [NBY-1:0] m, input logic ij);
      idle();
      we = 1'b1; addr = a; din = d; be = m; inj = ij;
      step();
      idle();
   endtask

   // Read a, checking bank a one edge later and bank b two edges later.
   task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      idle();
      re = 1'b1; addr = a;
      step();
      check("a.rd_valid", bus_a.dataValid, 1);
      check("a.rd_data", bus_a.dataOut, exp);
      idle();
      step();
      check("b.rd_valid", bus_b.dataValid, 1);
      check("b.rd_data", bus_b.dataOut, (int'(a) < DEP_B) ? exp : '0);
      check("b.rd_addr_err", bus_b.addrErr, int'(a) >= DEP_B);
   endtask

   // Counts observed busy cycles of each bank; inputs are left as the caller set them.
   task automatic measure_sweep(input string tag);
      int na = 0, nb = 0, n = 0;
      while ((bus_a.busy || bus_b.busy) && n < 2000) begin
         na += int'(bus_a.busy);
         nb += int'(bus_b.busy);
         step();
         n++;
      end
      check({tag, ".a_sweep_len"}, na, DEP_A);
      check({tag, ".b_sweep_len"}, nb, DEP_B);
   endtask

   task automatic wait_ready(input int limit);
      int n = 0;
      while ((busy_left[0] > 0 || busy_left[1] > 0) && n < limit) begin
         step();
         n++;
      end
      check("ready_timeout", n < limit, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // reset and initial sweep
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      measure_sweep("reset");
      read_chk(10'd0, 16'h0000);
      read_chk(10'd1, 16'h0000);
      read_chk(10'd1023, 16'h0000);

      // write / byte mask
      do_write(10'd1, 16'habcc, 2'b11, 1'b0);
      read_chk(10'd1, 16'habcc);
      do_write(10'd1, 16'h1234, 2'b01, 1'b0);
      read_chk(10'd1, 16'hab34);
      do_write(10'd1, 16'hffff, 2'b00, 1'b0);
      read_chk(10'd1, 16'hab34);

      // read-first on same-address write+read
      do_write(10'd2, 16'hbbdd, 2'b11, 1'b0);
      idle();
      we = 1'b1; re = 1'b1; addr = 10'd2; din = 16'h568e; be = 2'b11;
      step();
      check("a.read_first", bus_a.dataOut, 16'hbbdd);
      idle();
      step();
      check("b.read_first", bus_b.dataOut, 16'hbbdd);
      read_chk(10'd2, 16'h568e);

      // back-to-back pipelined reads
      do_write(10'd3, 16'h7777, 2'b11, 1'b0);
      idle();
      re = 1'b1; addr = 10'd1;
      step();
      check("a.b2b_1", bus_a.dataOut, 16'hab34);
      addr = 10'd2;
      step();
      check("a.b2b_2", bus_a.dataOut, 16'h568e);
      addr = 10'd3;
      step();
      check("a.b2b_3", bus_a.dataOut, 16'h7777);
      check("b.b2b_2", bus_b.dataOut, 16'h568e);
      idle();
      step();
      step();

      // out-of-range for bank b (in range for bank a)
      do_write(10'd1005, 16'h4242, 2'b11, 1'b0);
      read_chk(10'd1005, 16'h4242);

`ifdef MY_RAM_BANK_PARITY_EN
      do_write(10'd4, 16'h568a, 2'b11, 1'b1);
      idle(); re = 1'b1; addr = 10'd4;
      step();
      check("a.parity_inject", bus_a.parityErr, 1);
      idle();
      step();
      check("b.parity_inject", bus_b.parityErr, 1);
      do_write(10'd4, 16'h568a, 2'b11, 1'b0);
      idle(); re = 1'b1; addr = 10'd4;
      step();
      check("a.parity_clean", bus_a.parityErr, 0);
      idle();
      step();
      check("b.parity_clean", bus_b.parityErr, 0);
`endif

      // clearReq with a read on the same cycle, then reads while busy
      idle();
      clr = 1'b1; re = 1'b1; addr = 10'd1;
      step();
      check("a.pre_clear_read", bus_a.dataOut, 16'hab34);
      clr = 1'b0;
      measure_sweep("clear_req");
      idle();
      step();
      step();
      read_chk(10'd1, 16'h0000);

      // randomized traffic with one clear request in the middle
      for (int i = 0; i < 1200; i++) begin
         idle();
         we   = 1'($urandom_range(0, 1));
         re   = 1'($urandom_range(0, 1));
         be   = NBY'($urandom_range(0, 3));
         addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(990, 1023))
                                            : AW'($urandom_range(0, 15));
         din  = DW'($urandom);
`ifdef MY_RAM_BANK_PARITY_EN
         inj  = ($urandom_range(0, 7) == 0);
`endif
         clr  = (i == 600);
         step();
      end
      idle();
      wait_ready(1100);
      step();
      step();

      // reset in the middle of a sweep restarts it
      clr = 1'b1;
      step();
      idle();
      for (int i = 0; i < 300; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      measure_sweep("mid_reset");
      read_chk(10'd2, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      total++;
      bad++;
      $display("FAIL watchdog cycle=%0d got=running exp=finished", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
